mem_seq_unit: RTL and testbench

- Parametrised byte-serial load/store sequencer that moves 1..data_width/8 bytes, MSB first (big-endian), between a wide register value and a byte-wide memory port.
- Used by the next-generation robin core in place of the hard-coded LOADB/W/L and STORB/W/L state chains.
- Adds beyond the current core: mem_ready back-pressure, configurable read latency, optional sign extension, an illegal-size error, and a start/done handshake.

---
 rtl/mem_seq_unit_if.sv | 22 ++
 rtl/mem_seq_unit.sv | 180 ++++++++++++++++++
 tb/tb_mem_seq_unit.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_unit_if.sv
// Byte-wide memory port between mem_seq_unit (master) and a memory (slave).
// Ports: mem_raddr/mem_data_out read path, mem_waddr/mem_data_in/mem_write write path, mem_ready.
interface mem_seq_unit_if #(
   parameter int addr_width = 9
);
   logic [addr_width-1:0] mem_raddr;
   logic [7:0]            mem_data_out;
   logic [addr_width-1:0] mem_waddr;
   logic [7:0]            mem_data_in;
   logic                  mem_write;
   logic                  mem_ready;

   modport master (
      output mem_raddr, mem_waddr, mem_data_in, mem_write,
      input  mem_data_out, mem_ready
   );

   modport slave (
      input  mem_raddr, mem_waddr, mem_data_in, mem_write,
      output mem_data_out, mem_ready
   );
endinterface

// File: rtl/mem_seq_unit.sv
// Byte-serial big-endian load/store sequencer between a wide register and a byte memory.
// Ports: clk, reset, start/op_write/size/signext/addr/wdata in, rdata/busy/done/err out, mem (master).
module mem_seq_unit #(
   parameter int addr_width   = 9,
   parameter int data_width   = 32,
   parameter int read_latency = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  op_write,
   input  logic [1:0]            size,
   input  logic                  signext,
   input  logic [addr_width-1:0] addr,
   input  logic [data_width-1:0] wdata,
   output logic [data_width-1:0] rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   mem_seq_unit_if.master        mem
);
   localparam int NB = data_width / 8;
   localparam int CW = (read_latency > 1) ? $clog2(read_latency) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(read_latency - 1);

   typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_STROBE, FIN} state_t;

   state_t                state_q, state_d;
   logic [addr_width-1:0] mem_raddr_q, mem_raddr_d;
   logic [addr_width-1:0] mem_waddr_q, mem_waddr_d;
   logic [7:0]            mem_data_in_q, mem_data_in_d;
   logic [data_width-1:0] rdata_q, rdata_d;
   logic [data_width-1:0] acc_q, acc_d;
   logic [data_width-1:0] wbuf_q, wbuf_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [3:0]            left_q, left_d;
   logic [6:0]            nbits_q, nbits_d;
   logic                  signext_q, signext_d;
   logic                  err_q, err_d;

   logic [3:0]            n_req;
   logic [6:0]            nbits_req;
   logic                  legal;
   logic [7:0]            wshift;
   logic [data_width-1:0] walign;
   logic [data_width-1:0] acc_next;
   logic [data_width-1:0] mask;
   logic [data_width-1:0] sign_sh;

   always_comb begin
      n_req     = 4'd1 << size;
      nbits_req = {n_req, 3'b000};
      legal     = (int'(n_req) <= NB);
      // left-justify the store bytes so the next byte is always the top one
      wshift    = 8'(data_width) - {1'b0, nbits_req};
      walign    = wdata << wshift;
      acc_next  = (acc_q << 8) | data_width'(mem.mem_data_out);
      mask      = ~({data_width{1'b1}} << nbits_q);
      sign_sh   = acc_next >> (nbits_q - 7'd1);
   end

   always_comb begin
      state_d       = state_q;
      mem_raddr_d   = mem_raddr_q;
      mem_waddr_d   = mem_waddr_q;
      mem_data_in_d = mem_data_in_q;
      rdata_d       = rdata_q;
      acc_d         = acc_q;
      wbuf_d        = wbuf_q;
      cnt_d         = cnt_q;
      left_d        = left_q;
      nbits_d       = nbits_q;
      signext_d     = signext_q;
      err_d         = err_q;
      unique case (state_q)
         IDLE, FIN: begin
            state_d = IDLE;
            if (start) begin
               err_d = !legal;
               if (!legal) begin
                  state_d = FIN;
               end else if (op_write) begin
                  mem_waddr_d   = addr;
                  wbuf_d        = walign;
                  mem_data_in_d = walign[data_width-1 -: 8];
                  left_d        = n_req;
                  state_d       = WR_STROBE;
               end else begin
                  mem_raddr_d = addr;
                  acc_d       = '0;
                  cnt_d       = '0;
                  left_d      = n_req;
                  nbits_d     = nbits_req;
                  signext_d   = signext;
                  state_d     = RD;
               end
            end
         end
         RD: begin
            // counter saturates at the sample edge; stalls just retry
            if (cnt_q == CNT_LAST) begin
               if (mem.mem_ready) begin
                  acc_d  = acc_next;
                  cnt_d  = '0;
                  left_d = left_q - 4'd1;
                  if (left_q == 4'd1) begin
                     if (signext_q && sign_sh[0]) begin
                        rdata_d = acc_next | ~mask;
                     end else begin
                        rdata_d = acc_next & mask;
                     end
                     state_d = FIN;
                  end else begin
                     mem_raddr_d = mem_raddr_q + addr_width'(1);
                  end
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WR_STROBE: begin
            if (mem.mem_ready) begin
               state_d = WR_SETUP;
            end
         end
         WR_SETUP: begin
            if (left_q == 4'd1) begin
               state_d = FIN;
            end else begin
               mem_waddr_d   = mem_waddr_q + addr_width'(1);
               wbuf_d        = wbuf_q << 8;
               mem_data_in_d = wbuf_d[data_width-1 -: 8];
               left_d        = left_q - 4'd1;
               state_d       = WR_STROBE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         mem_raddr_q   <= '0;
         mem_waddr_q   <= '0;
         mem_data_in_q <= '0;
         rdata_q       <= '0;
         acc_q         <= '0;
         wbuf_q        <= '0;
         cnt_q         <= '0;
         left_q        <= '0;
         nbits_q       <= '0;
         signext_q     <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_raddr_q   <= mem_raddr_d;
         mem_waddr_q   <= mem_waddr_d;
         mem_data_in_q <= mem_data_in_d;
         rdata_q       <= rdata_d;
         acc_q         <= acc_d;
         wbuf_q        <= wbuf_d;
         cnt_q         <= cnt_d;
         left_q        <= left_d;
         nbits_q       <= nbits_d;
         signext_q     <= signext_d;
         err_q         <= err_d;
      end
   end

   // the strobe cycle is exactly the WR_SETUP state, so it can never repeat
   assign busy            = (state_q == RD) || (state_q == WR_SETUP) || (state_q == WR_STROBE);
   assign done            = (state_q == FIN);
   assign err             = err_q;
   assign rdata           = rdata_q;
   assign mem.mem_raddr   = mem_raddr_q;
   assign mem.mem_waddr   = mem_waddr_q;
   assign mem.mem_data_in = mem_data_in_q;
   assign mem.mem_write   = (state_q == WR_SETUP);
endmodule

// File: tb/tb_mem_seq_unit.sv
// Self-checking bench for mem_seq_unit: timeline model of each operation plus directed cases.
// Memory slave has one register stage, matching read_latency = 2.
module tb_mem_seq_unit;
   localparam int AW = 9;
   localparam int DW = 32;
   localparam int RL = 2;
   localparam int MAXT = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          op_write;
   logic [1:0]    size;
   logic          signext;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          busy;
   logic          done;
   logic          err;
   logic          ready;

   mem_seq_unit_if #(.addr_width(AW)) mif ();

   mem_seq_unit #(
      .addr_width(AW), .data_width(DW), .read_latency(RL)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .op_write(op_write),
      .size(size), .signext(signext), .addr(addr), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done), .err(err), .mem(mif)
   );

   always #5 clk = ~clk;

   logic [7:0] mem_arr [512];
   logic [7:0] rd_q;
   always @(posedge clk) rd_q <= mem_arr[mif.mem_raddr];
   assign mif.mem_data_out = rd_q;
   assign mif.mem_ready    = ready;

   int n_pass = 0;
   int n_chk  = 0;

   // expected state after edge t of the current operation (t = 0 is the accept edge)
   logic          e_busy [MAXT], e_done [MAXT], e_wr [MAXT], e_err [MAXT];
   logic [AW-1:0] e_raddr [MAXT], e_waddr [MAXT];
   logic [7:0]    e_wdat [MAXT];
   logic [DW-1:0] e_rdata [MAXT];
   logic          n_busy [MAXT], n_done [MAXT], n_wr [MAXT], n_err [MAXT];
   logic [AW-1:0] n_raddr [MAXT], n_waddr [MAXT];
   logic [7:0]    n_wdat [MAXT];
   logic [DW-1:0] n_rdata [MAXT];
   int            n_T;
   int            n_abort;
   bit            rdy [MAXT];

   int            ph = 0;
   bit            idle = 1'b1;
   bit            chk_en = 1'b0;
   int            done_t;
   int            busy_n;
   logic [AW-1:0] wr_a [$];
   logic [7:0]    wr_d [$];

   task automatic chk(input string nm, input int t, input logic [63:0] a, input logic [63:0] e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s t=%0d got %0h want %0h", nm, t, a, e);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", ph, 64'(busy), idle ? 64'd0 : 64'(e_busy[ph]));
         chk("done", ph, 64'(done), idle ? 64'd0 : 64'(e_done[ph]));
         chk("mem_write", ph, 64'(mif.mem_write), idle ? 64'd0 : 64'(e_wr[ph]));
         chk("err", ph, 64'(err), 64'(e_err[ph]));
         chk("rdata", ph, 64'(rdata), 64'(e_rdata[ph]));
         chk("mem_raddr", ph, 64'(mif.mem_raddr), 64'(e_raddr[ph]));
         chk("mem_waddr", ph, 64'(mif.mem_waddr), 64'(e_waddr[ph]));
         if (!idle && e_wr[ph])
            chk("mem_data_in", ph, 64'(mif.mem_data_in), 64'(e_wdat[ph]));
         if (!idle) begin
            if (done) done_t = ph;
            if (busy) busy_n++;
            if (mif.mem_write) begin
               wr_a.push_back(mif.mem_waddr);
               wr_d.push_back(mif.mem_data_in);
            end
         end
      end
   end

   task automatic put(input int t, input logic b, input logic d, input logic w,
                      input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                      input logic [7:0] wd, input logic [DW-1:0] rd, input logic er);
      n_busy[t] = b; n_done[t] = d; n_wr[t] = w; n_raddr[t] = ra;
      n_waddr[t] = wa; n_wdat[t] = wd; n_rdata[t] = rd; n_err[t] = er;
   endtask

   // timeline of one request from the rules: latency, stalls, strobe/setup pairs
   task automatic plan(input logic opw, input logic [1:0] sz, input logic sx,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd, input int abort_at);
      int n, t, e;
      logic [AW-1:0] ra, wa;
      logic [DW-1:0] rd;
      logic [63:0] v;
      logic [7:0] b;
      ra = e_raddr[ph]; wa = e_waddr[ph]; rd = e_rdata[ph];
      n = 1 << sz;
      t = 0;
      if (n > DW / 8) begin
         put(0, 0, 1, 0, ra, wa, 8'd0, rd, 1);
      end else if (!opw) begin
         ra = a; v = 0;
         put(0, 1, 0, 0, ra, wa, 8'd0, rd, 0);
         for (int k = 0; k < n; k++) begin
            for (e = t + 1; e < t + RL; e++) put(e, 1, 0, 0, ra, wa, 8'd0, rd, 0);
            while (!rdy[e]) begin put(e, 1, 0, 0, ra, wa, 8'd0, rd, 0); e++; end
            v = (v << 8) | 64'(mem_arr[AW'(int'(a) + k)]);
            if (k < n - 1) begin
               ra = ra + 1'b1;
               put(e, 1, 0, 0, ra, wa, 8'd0, rd, 0);
            end else begin
               if (sx && v[8 * n - 1]) rd = DW'(v | ~((64'd1 << (8 * n)) - 64'd1));
               else rd = DW'(v);
               put(e, 0, 1, 0, ra, wa, 8'd0, rd, 0);
            end
            t = e;
         end
      end else begin
         wa = a;
         put(0, 1, 0, 0, ra, wa, 8'd0, rd, 0);
         for (int k = 0; k < n; k++) begin
            e = t + 1;
            while (!rdy[e]) begin put(e, 1, 0, 0, ra, wa, 8'd0, rd, 0); e++; end
            b = wd[8 * (n - 1 - k) +: 8];
            put(e, 1, 0, 1, ra, wa, b, rd, 0);
            e++;
            if (k < n - 1) begin
               wa = wa + 1'b1;
               put(e, 1, 0, 0, ra, wa, 8'd0, rd, 0);
            end else begin
               put(e, 0, 1, 0, ra, wa, 8'd0, rd, 0);
            end
            t = e;
         end
      end
      n_abort = -1;
      if (abort_at >= 1 && abort_at <= t) begin
         put(abort_at, 0, 0, 0, '0, '0, 8'd0, '0, 0);
         t = abort_at;
         n_abort = abort_at;
      end
      n_T = t;
   endtask

   task automatic run_op(input logic opw, input logic [1:0] sz, input logic sx,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int abort_at, input bit poke);
      plan(opw, sz, sx, a, wd, abort_at);
      start = 1'b1; op_write = opw; size = sz; signext = sx; addr = a; wdata = wd;
      ready = rdy[0];
      for (int t = 0; t <= n_T; t++) begin
         @(posedge clk);
         #1;
         if (t == 0) begin
            e_busy = n_busy; e_done = n_done; e_wr = n_wr; e_err = n_err;
            e_raddr = n_raddr; e_waddr = n_waddr; e_wdat = n_wdat; e_rdata = n_rdata;
            idle = 1'b0; done_t = -1; busy_n = 0;
            wr_a.delete(); wr_d.delete();
         end
         ph = t;
         start = 1'b0;
         op_write = 1'($urandom); size = 2'($urandom); signext = 1'($urandom);
         addr = AW'($urandom); wdata = $urandom;
         if (poke && t == 0 && e_busy[0] && n_T > 1) start = 1'b1;
         ready = rdy[t + 1];
         reset = (n_abort >= 1 && t + 1 == n_abort);
      end
      @(negedge clk);
      #1;
   endtask

   task automatic gap(input int g);
      if (g > 0) begin
         idle = 1'b1;
         repeat (g) @(posedge clk);
         #1;
      end
   endtask

   task automatic rdy_all();
      for (int i = 0; i < MAXT; i++) rdy[i] = 1'b1;
   endtask

   task automatic rdy_rand();
      for (int i = 0; i < MAXT; i++) rdy[i] = (i >= 32) || ($urandom % 4 != 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op_write = 1'b0; size = 2'd0; signext = 1'b0;
      addr = '0; wdata = '0; ready = 1'b1;
      for (int i = 0; i < MAXT; i++) begin
         e_busy[i] = 0; e_done[i] = 0; e_wr[i] = 0; e_err[i] = 0;
         e_raddr[i] = '0; e_waddr[i] = '0; e_wdat[i] = '0; e_rdata[i] = '0;
      end
      for (int i = 0; i < 512; i++) mem_arr[i] = 8'($urandom);
      mem_arr[9'h010] = 8'h12; mem_arr[9'h011] = 8'h34;
      mem_arr[9'h012] = 8'h56; mem_arr[9'h013] = 8'h78;
      mem_arr[9'h020] = 8'h80;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 0, 64'(busy), 0);
      chk("rst_done", 0, 64'(done), 0);
      chk("rst_err", 0, 64'(err), 0);
      chk("rst_rdata", 0, 64'(rdata), 0);
      chk("rst_raddr", 0, 64'(mif.mem_raddr), 0);
      chk("rst_waddr", 0, 64'(mif.mem_waddr), 0);
      chk("rst_wdin", 0, 64'(mif.mem_data_in), 0);
      chk("rst_mem_write", 0, 64'(mif.mem_write), 0);
      #1;
      chk_en = 1'b1;

      rdy_all();
      run_op(1'b0, 2'd2, 1'b0, 9'h010, '0, -1, 1'b1);
      chk("mdl_ld_T", 0, 64'(n_T), 8);
      chk("mdl_ld_rdata", 0, 64'(e_rdata[ph]), 64'h12345678);
      chk("ld_rdata", 0, 64'(rdata), 64'h12345678);
      chk("ld_done_t", 0, 64'(done_t), 8);
      chk("ld_busy_n", 0, 64'(busy_n), 8);

      run_op(1'b0, 2'd0, 1'b1, 9'h020, '0, -1, 1'b0);
      chk("ldb_sx", 0, 64'(rdata), 64'hFFFFFF80);
      chk("ldb_done_t", 0, 64'(done_t), 2);
      gap(1);
      run_op(1'b0, 2'd0, 1'b0, 9'h020, '0, -1, 1'b0);
      chk("ldb_zx", 0, 64'(rdata), 64'h00000080);

      run_op(1'b1, 2'd1, 1'b0, 9'h1FF, 32'h0000BEEF, -1, 1'b1);
      chk("st_strobes", 0, 64'(wr_a.size()), 2);
      chk("st_done_t", 0, 64'(done_t), 4);
      chk("st_rdata_kept", 0, 64'(rdata), 64'h00000080);
      if (wr_a.size() >= 2) begin
         chk("st_a0", 0, 64'(wr_a[0]), 64'h1FF);
         chk("st_d0", 0, 64'(wr_d[0]), 64'hBE);
         chk("st_a1", 1, 64'(wr_a[1]), 64'h000);
         chk("st_d1", 1, 64'(wr_d[1]), 64'hEF);
      end

      rdy[4] = 1'b0; rdy[5] = 1'b0; rdy[6] = 1'b0;
      run_op(1'b0, 2'd2, 1'b0, 9'h010, '0, -1, 1'b0);
      chk("mdl_stall_T", 0, 64'(n_T), 11);
      chk("stall_done_t", 0, 64'(done_t), 11);
      chk("stall_rdata", 0, 64'(rdata), 64'h12345678);
      rdy_all();

      gap(2);
      run_op(1'b0, 2'd3, 1'b0, 9'h033, '0, -1, 1'b0);
      chk("ill_done_t", 0, 64'(done_t), 0);
      chk("ill_err", 0, 64'(err), 1);
      chk("ill_busy_n", 0, 64'(busy_n), 0);
      chk("ill_strobes", 0, 64'(wr_a.size()), 0);
      run_op(1'b1, 2'd0, 1'b0, 9'h055, 32'h000000A5, -1, 1'b0);
      chk("ill_err_clr", 0, 64'(err), 0);

      run_op(1'b1, 2'd2, 1'b0, 9'h100, 32'hCAFEF00D, 4, 1'b1);
      chk("rst_st_strobes", 0, 64'(wr_a.size()), 2);
      chk("rst_st_busy", 0, 64'(busy), 0);
      chk("rst_st_mem_write", 0, 64'(mif.mem_write), 0);
      gap(1);
      run_op(1'b0, 2'd2, 1'b0, 9'h010, '0, -1, 1'b0);
      chk("post_rst_rdata", 0, 64'(rdata), 64'h12345678);
      chk("post_rst_done_t", 0, 64'(done_t), 8);

      for (int i = 0; i < 80; i++) begin
         rdy_rand();
         run_op(1'($urandom), 2'($urandom), 1'($urandom), AW'($urandom), $urandom,
                ($urandom % 8 == 0) ? 1 + int'($urandom % 4) : -1, 1'($urandom));
         gap(int'($urandom % 3));
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
